// File: rtl/run_control_issuer.sv
// Host command issuer for the task-clock interruption logic; optional HIT_COUNTER_EN adds a saturating breakpoint-hit counter.
// Accept edge -> clk_en change one cycle later; cmd_ready drops for the duration of a STEP burst.
module run_control_issuer #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_arg,
    input  logic [DATA_W-1:0] count_out,
    output logic              clk_en,
    output logic [DATA_W-1:0] breakpoint,
    output logic              halted,
    output logic              bp_hit
`ifdef HIT_COUNTER_EN
    ,
    output logic [15:0]       hit_count
`endif
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    localparam logic [1:0] OP_HALT   = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SET_BP = 2'b11;

    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_ZERO = '0;

    state_t              state_q, state_d;
    logic                clk_en_q, clk_en_d;
    logic [DATA_W-1:0]   bp_q, bp_d;
    logic                halted_q, halted_d;
    logic                bp_hit_q, bp_hit_d;
    logic                ready_q, ready_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;

    logic                accept;
    logic                bp_match;
    logic [STEP_W-1:0]   step_arg;

    assign accept   = cmd_valid && ready_q;
    assign bp_match = clk_en_q && (count_out == bp_q);
    assign step_arg = cmd_arg[STEP_W-1:0];

    always_comb begin
        state_d    = state_q;
        clk_en_d   = clk_en_q;
        bp_d       = bp_q;
        bp_hit_d   = 1'b0;
        step_cnt_d = step_cnt_q;

        case (state_q)
            ST_HALTED: begin
                if (accept) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d  = ST_RUN;
                            clk_en_d = 1'b1;
                        end
                        OP_STEP: begin
                            if (step_arg != STEP_ZERO) begin
                                state_d    = ST_STEP;
                                step_cnt_d = step_arg;
                                clk_en_d   = 1'b1;
                            end
                        end
                        OP_SET_BP: bp_d = cmd_arg;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Breakpoint takes precedence so a coinciding HALT still reports the hit.
                if (bp_match) begin
                    state_d  = ST_HALTED;
                    clk_en_d = 1'b0;
                    bp_hit_d = 1'b1;
                end else if (accept && cmd_op == OP_HALT) begin
                    state_d  = ST_HALTED;
                    clk_en_d = 1'b0;
                end
                if (accept && cmd_op == OP_SET_BP) begin
                    bp_d = cmd_arg;
                end
            end
            ST_STEP: begin
                if (clk_en_q) begin
                    step_cnt_d = step_cnt_q - STEP_ONE;
                    if (step_cnt_q == STEP_ONE) begin
                        state_d  = ST_HALTED;
                        clk_en_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_HALTED;
                clk_en_d = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALTED);
        ready_d  = (state_d != ST_STEP);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q    <= ST_HALTED;
            clk_en_q   <= 1'b0;
            bp_q       <= '1;
            halted_q   <= 1'b1;
            bp_hit_q   <= 1'b0;
            ready_q    <= 1'b1;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clk_en_q   <= clk_en_d;
            bp_q       <= bp_d;
            halted_q   <= halted_d;
            bp_hit_q   <= bp_hit_d;
            ready_q    <= ready_d;
            step_cnt_q <= step_cnt_d;
        end
    end

`ifdef HIT_COUNTER_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;

    // Counts alongside the bp_hit pulse; a new breakpoint restarts the tally.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (accept && cmd_op == OP_SET_BP) begin
            hit_cnt_d = 16'd0;
        end else if (bp_hit_d && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            hit_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_count = hit_cnt_q;
`endif

    assign cmd_ready  = ready_q;
    assign clk_en     = clk_en_q;
    assign breakpoint = bp_q;
    assign halted     = halted_q;
    assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_run_control_issuer.sv
// Directed bench for run_control_issuer; a simple task counter advances on each edge where clk_en was high.
module tb_run_control_issuer;

    localparam logic [1:0] OP_HALT   = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SET_BP = 2'b11;

    logic        sys_clk;
    logic        sys_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [31:0] count_out;
    logic        clk_en;
    logic [31:0] breakpoint;
    logic        halted;
    logic        bp_hit;
`ifdef HIT_COUNTER_EN
    logic [15:0] hit_count;
`endif

    int n_vec;
    int n_err;

    run_control_issuer #(.DATA_W(32), .STEP_W(16)) dut (
        .sys_clk    (sys_clk),
        .sys_reset  (sys_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .count_out  (count_out),
        .clk_en     (clk_en),
        .breakpoint (breakpoint),
        .halted     (halted),
        .bp_hit     (bp_hit)
`ifdef HIT_COUNTER_EN
        ,
        .hit_count  (hit_count)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock; the modelled task counter advances if clk_en was high going into the edge.
    task automatic tick();
        logic en_prev;
        en_prev = clk_en;
        @(posedge sys_clk);
        #1;
        if (en_prev) count_out = count_out + 32'd1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 32'd0;
    endtask

    task automatic run_to_halt(output int cyc, output logic [31:0] last);
        cyc  = 0;
        last = count_out;
        for (int i = 0; i < 400 && clk_en; i++) begin
            last = count_out;
            tick();
            cyc++;
        end
        if (clk_en) chk("halt_timeout", {31'd0, clk_en}, 32'd0);
    endtask

    initial begin
        int          cyc;
        int          n_high;
        logic        ready_seen;
        logic        en_seen;
        logic [31:0] last;

        n_vec     = 0;
        n_err     = 0;
        sys_reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 32'd0;
        count_out = 32'd0;

        tick();
        tick();
        sys_reset = 1'b0;
        chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_bp", breakpoint, 32'hFFFF_FFFF);
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Breakpoint at 100: RUN must stop the cycle after the counter shows 100.
        send(OP_SET_BP, 32'd100);
        chk("setbp_load", breakpoint, 32'd100);
        chk("setbp_still_halted", {31'd0, halted}, 32'd1);
        count_out = 32'd0;
        send(OP_RUN, 32'd0);
        chk("run_clk_en", {31'd0, clk_en}, 32'd1);
        chk("run_halted", {31'd0, halted}, 32'd0);
        run_to_halt(cyc, last);
        chk("bp100_last_cnt", last, 32'd100);
        chk("bp100_cycles", cyc, 32'd101);
        chk("bp100_hit", {31'd0, bp_hit}, 32'd1);
        chk("bp100_halted", {31'd0, halted}, 32'd1);
        tick();
        chk("bp100_hit_pulse", {31'd0, bp_hit}, 32'd0);

        // STEP 5: exactly five enabled cycles, host locked out meanwhile.
        send(OP_STEP, 32'd5);
        n_high     = 0;
        ready_seen = 1'b0;
        for (int i = 0; i < 20 && clk_en; i++) begin
            n_high++;
            ready_seen = ready_seen | cmd_ready;
            tick();
        end
        chk("step5_cycles", n_high, 32'd5);
        chk("step5_ready_low", {31'd0, ready_seen}, 32'd0);
        chk("step5_halted", {31'd0, halted}, 32'd1);
        chk("step5_ready_back", {31'd0, cmd_ready}, 32'd1);

        // STEP 0 and a STEP whose nonzero bits lie above STEP_W both do nothing.
        send(OP_STEP, 32'd0);
        en_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en_seen = en_seen | clk_en;
            tick();
        end
        send(OP_STEP, 32'h0001_0000);
        en_seen = en_seen | clk_en;
        chk("step0_no_clk", {31'd0, en_seen}, 32'd0);
        chk("step0_halted", {31'd0, halted}, 32'd1);

        // Plain HALT while running: no breakpoint report.
        count_out = 32'd0;
        send(OP_RUN, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("run_ready", {31'd0, cmd_ready}, 32'd1);
        send(OP_HALT, 32'd0);
        chk("halt_clk_en", {31'd0, clk_en}, 32'd0);
        chk("halt_no_hit", {31'd0, bp_hit}, 32'd0);
        chk("halt_halted", {31'd0, halted}, 32'd1);

        // HALT accepted on the same edge the counter equals the breakpoint.
        send(OP_SET_BP, 32'd20);
        count_out = 32'd0;
        send(OP_RUN, 32'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("coinc_cnt", count_out, 32'd20);
        send(OP_HALT, 32'd0);
        chk("coinc_hit", {31'd0, bp_hit}, 32'd1);
        chk("coinc_clk_en", {31'd0, clk_en}, 32'd0);

        // SET_BP during RUN on the match cycle: old value still stops the run.
        send(OP_SET_BP, 32'd50);
        count_out = 32'd0;
        send(OP_RUN, 32'd0);
        for (int i = 0; i < 50; i++) tick();
        send(OP_SET_BP, 32'd60);
        chk("swap50_hit", {31'd0, bp_hit}, 32'd1);
        chk("swap50_clk_en", {31'd0, clk_en}, 32'd0);
        chk("swap50_newbp", breakpoint, 32'd60);

        // SET_BP during RUN before the match: run continues to the new value.
        send(OP_SET_BP, 32'd50);
        count_out = 32'd0;
        send(OP_RUN, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        send(OP_SET_BP, 32'd60);
        chk("swap40_running", {31'd0, clk_en}, 32'd1);
        chk("swap40_newbp", breakpoint, 32'd60);
        run_to_halt(cyc, last);
        chk("swap40_last_cnt", last, 32'd60);
        chk("swap40_hit", {31'd0, bp_hit}, 32'd1);

        // Three breakpoint stops in a row.
        send(OP_SET_BP, 32'd5);
        for (int k = 0; k < 3; k++) begin
            count_out = 32'd0;
            send(OP_RUN, 32'd0);
            run_to_halt(cyc, last);
            chk("hit3_last_cnt", last, 32'd5);
            chk("hit3_pulse", {31'd0, bp_hit}, 32'd1);
        end
`ifdef HIT_COUNTER_EN
        chk("hitcnt_three", {16'd0, hit_count}, 32'd3);
        send(OP_SET_BP, 32'd7);
        chk("hitcnt_clear", {16'd0, hit_count}, 32'd0);
`endif

        // Synchronous reset in the third cycle of an 8-cycle STEP.
        send(OP_STEP, 32'd8);
        tick();
        tick();
        chk("rstmid_stepping", {31'd0, clk_en}, 32'd1);
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        chk("rstmid_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rstmid_halted", {31'd0, halted}, 32'd1);
        chk("rstmid_no_hit", {31'd0, bp_hit}, 32'd0);
        chk("rstmid_bp", breakpoint, 32'hFFFF_FFFF);
        chk("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef HIT_COUNTER_EN
        chk("rstmid_hitcnt", {16'd0, hit_count}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
